// File: rtl/decoder_scan_pkg.sv
// Shared types and helpers for the scanning one-cold decoder.
// Optional blanking between scan steps: BREAK_BEFORE_MAKE_EN.
package decoder_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam int MAX_SEL_W = 6;

    function automatic int unsigned n_out(
        input int unsigned sel_w
    );
        return 32'd1 << sel_w;
    endfunction

    // Legacy ordering: index 0 lives in the MSB of the output bus.
    function automatic logic [63:0] onecold(
        input int unsigned idx,
        input int unsigned sel_w
    );
        logic [63:0] r;
        r = '1;
        r[6'(n_out(sel_w) - 32'd1 - idx)] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/decoder_scan_n_if.sv
// Control/status bundle between a select master and the decoder.
// Optional blanking between scan steps: BREAK_BEFORE_MAKE_EN.
interface decoder_scan_n_if #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
);

    localparam int N_OUT = 2 ** SEL_W;

    logic               en_n;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic [DWELL_W-1:0] dwell;
    logic [N_OUT-1:0]   d_n;
    logic [SEL_W-1:0]   cur_idx;
    logic               wrap;

    modport master (
        output en_n,
        output mode,
        output sel,
        output dwell,
        input  d_n,
        input  cur_idx,
        input  wrap
    );

    modport slave (
        input  en_n,
        input  mode,
        input  sel,
        input  dwell,
        output d_n,
        output cur_idx,
        output wrap
    );

endinterface

// File: rtl/decoder_scan_n_dwell_timer.sv
// Loadable down-counter that times one scan step.
// Optional blanking between scan steps: BREAK_BEFORE_MAKE_EN.
module dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               load,
    input  logic               dec,
    input  logic [DWELL_W-1:0] din,
    output logic               zero
);

    logic [DWELL_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= din;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/decoder_scan_n.sv
// Registered SEL_W-to-2^SEL_W one-cold decoder with a scan sequencer.
// Optional blanking between scan steps: BREAK_BEFORE_MAKE_EN.
module decoder_scan_n
    import decoder_scan_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    decoder_scan_n_if.slave   bus
);

    localparam int N_OUT = int'(n_out(SEL_W));

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_DIRECT = DIRECT;
    localparam logic [1:0] S_SCAN   = SCAN;

    generate
        if (SEL_W < 1 || SEL_W > MAX_SEL_W) begin : g_bad_sel_w
            $error("decoder_scan_n: SEL_W out of range");
        end
    endgenerate

    function automatic logic [N_OUT-1:0] decode(
        input logic [SEL_W-1:0] i
    );
        logic [63:0] w;
        w = onecold(32'(i), SEL_W);
        return N_OUT'(w);
    endfunction

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [N_OUT-1:0] dn_q;
    logic [N_OUT-1:0] dn_d;
    logic [SEL_W-1:0] idx_q;
    logic [SEL_W-1:0] idx_d;
    logic [SEL_W-1:0] idx_inc;
    logic             wrap_q;
    logic             wrap_d;
    logic             t_clr;
    logic             t_load;
    logic             t_dec;
    logic             t_zero;
`ifdef BREAK_BEFORE_MAKE_EN
    logic             blank_q;
    logic             blank_d;
`endif

    assign idx_inc = idx_q + 1'b1;

    // en_n wins over mode; any non-scan state re-enters scan at index 0.
    always_comb begin
        state_d = state_q;
        dn_d    = dn_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        t_clr   = 1'b0;
        t_load  = 1'b0;
        t_dec   = 1'b0;
`ifdef BREAK_BEFORE_MAKE_EN
        blank_d = blank_q;
`endif
        if (bus.en_n) begin
            state_d = S_IDLE;
            dn_d    = '1;
            idx_d   = '0;
            t_clr   = 1'b1;
`ifdef BREAK_BEFORE_MAKE_EN
            blank_d = 1'b0;
`endif
        end else if (!bus.mode) begin
            state_d = S_DIRECT;
            dn_d    = decode(bus.sel);
            idx_d   = bus.sel;
            t_clr   = 1'b1;
`ifdef BREAK_BEFORE_MAKE_EN
            blank_d = 1'b0;
`endif
        end else if (state_q != S_SCAN) begin
            state_d = S_SCAN;
            dn_d    = decode('0);
            idx_d   = '0;
            t_load  = 1'b1;
`ifdef BREAK_BEFORE_MAKE_EN
            blank_d = 1'b0;
        end else if (blank_q) begin
            // dwell is sampled as the new index becomes visible
            dn_d    = decode(idx_q);
            blank_d = 1'b0;
            t_load  = 1'b1;
        end else if (t_zero) begin
            dn_d    = '1;
            idx_d   = idx_inc;
            wrap_d  = (idx_inc == '0);
            blank_d = 1'b1;
`else
        end else if (t_zero) begin
            dn_d    = decode(idx_inc);
            idx_d   = idx_inc;
            wrap_d  = (idx_inc == '0);
            t_load  = 1'b1;
`endif
        end else begin
            t_dec   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dn_q    <= '1;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dn_q    <= dn_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef BREAK_BEFORE_MAKE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= 1'b0;
        end else begin
            blank_q <= blank_d;
        end
    end
`endif

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (t_clr),
        .load  (t_load),
        .dec   (t_dec),
        .din   (bus.dwell),
        .zero  (t_zero)
    );

    assign bus.d_n     = dn_q;
    assign bus.cur_idx = idx_q;
    assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Directed bench for decoder_scan_n (SEL_W=2, DWELL_W=8).
// Also covers the BREAK_BEFORE_MAKE_EN build when that macro is set.
module tb_decoder_scan_n;

    localparam int SEL_W   = 2;
    localparam int DWELL_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] dn_tab [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    decoder_scan_n_if #(
        .SEL_W   (SEL_W),
        .DWELL_W (DWELL_W)
    ) bus ();

    decoder_scan_n #(
        .SEL_W   (SEL_W),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // No cycle may ever assert two outputs.
    always @(negedge clk) begin
        n_cmp++;
        if ($countones(~bus.d_n) > 1) begin
            n_bad++;
            $display("FAIL onecold d_n=%b", bus.d_n);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus.en_n  = 1'b1;
        bus.mode  = 1'b0;
        bus.sel   = '0;
        bus.dwell = '0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.d_n !== 4'b1111) begin
            n_bad++;
            $display("FAIL reset_dn got=%b exp=1111", bus.d_n);
        end
        n_cmp++;
        if (bus.cur_idx !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_idx got=%0d exp=0", bus.cur_idx);
        end
        n_cmp++;
        if (bus.wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_wrap got=%b exp=0", bus.wrap);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (bus.d_n !== 4'b1111) begin
            n_bad++;
            $display("FAIL idle_dn got=%b exp=1111", bus.d_n);
        end
    endtask

    task automatic test_direct;
        bus.en_n = 1'b0;
        bus.mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.sel = 2'(i);
            tick();
            n_cmp++;
            if (bus.d_n !== dn_tab[i]) begin
                n_bad++;
                $display("FAIL direct_dn sel=%0d got=%b exp=%b",
                         i, bus.d_n, dn_tab[i]);
            end
            n_cmp++;
            if (bus.cur_idx !== 2'(i)) begin
                n_bad++;
                $display("FAIL direct_idx got=%0d exp=%0d",
                         bus.cur_idx, i);
            end
            n_cmp++;
            if (bus.wrap !== 1'b0) begin
                n_bad++;
                $display("FAIL direct_wrap got=%b exp=0", bus.wrap);
            end
        end
    endtask

    task automatic test_enable;
        bus.sel = 2'd2;
        tick();
        n_cmp++;
        if (bus.d_n !== 4'b1101) begin
            n_bad++;
            $display("FAIL en_pre got=%b exp=1101", bus.d_n);
        end
        bus.en_n = 1'b1;
        tick();
        n_cmp++;
        if (bus.d_n !== 4'b1111) begin
            n_bad++;
            $display("FAIL en_off_dn got=%b exp=1111", bus.d_n);
        end
        n_cmp++;
        if (bus.cur_idx !== 2'd0) begin
            n_bad++;
            $display("FAIL en_off_idx got=%0d exp=0", bus.cur_idx);
        end
        bus.en_n = 1'b0;
        tick();
        n_cmp++;
        if (bus.d_n !== 4'b1101) begin
            n_bad++;
            $display("FAIL en_on_dn got=%b exp=1101", bus.d_n);
        end
        n_cmp++;
        if (bus.cur_idx !== 2'd2) begin
            n_bad++;
            $display("FAIL en_on_idx got=%0d exp=2", bus.cur_idx);
        end
    endtask

`ifndef BREAK_BEFORE_MAKE_EN
    task automatic test_scan;
        int ei;
        bus.mode  = 1'b1;
        bus.dwell = 8'd2;
        for (int c = 0; c < 15; c++) begin
            tick();
            ei = (c / 3) % 4;
            n_cmp++;
            if (bus.d_n !== dn_tab[ei]) begin
                n_bad++;
                $display("FAIL scan_dn c=%0d got=%b exp=%b",
                         c, bus.d_n, dn_tab[ei]);
            end
            n_cmp++;
            if (bus.cur_idx !== 2'(ei)) begin
                n_bad++;
                $display("FAIL scan_idx c=%0d got=%0d exp=%0d",
                         c, bus.cur_idx, ei);
            end
            n_cmp++;
            if (bus.wrap !== (c == 12)) begin
                n_bad++;
                $display("FAIL scan_wrap c=%0d got=%b exp=%b",
                         c, bus.wrap, (c == 12));
            end
        end
    endtask

    task automatic test_dwell_change;
        int seq [7] = '{0, 0, 0, 1, 2, 3, 0};
        bus.en_n = 1'b1;
        tick();
        n_cmp++;
        if (bus.d_n !== 4'b1111) begin
            n_bad++;
            $display("FAIL pulse_dn got=%b exp=1111", bus.d_n);
        end
        bus.en_n = 1'b0;
        for (int c = 0; c < 7; c++) begin
            tick();
            if (c == 0) bus.dwell = 8'd0;
            n_cmp++;
            if (bus.d_n !== dn_tab[seq[c]]) begin
                n_bad++;
                $display("FAIL dchg_dn c=%0d got=%b exp=%b",
                         c, bus.d_n, dn_tab[seq[c]]);
            end
            n_cmp++;
            if (bus.wrap !== (c == 6)) begin
                n_bad++;
                $display("FAIL dchg_wrap c=%0d got=%b exp=%b",
                         c, bus.wrap, (c == 6));
            end
        end
    endtask
`else
    task automatic test_bbm;
        logic [3:0] edn [14] = '{
            4'b0111, 4'b0111, 4'b1111, 4'b1011, 4'b1011,
            4'b1111, 4'b1101, 4'b1101, 4'b1111, 4'b1110,
            4'b1110, 4'b1111, 4'b0111, 4'b0111};
        int eidx [14] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0};
        bus.en_n = 1'b1;
        tick();
        bus.en_n  = 1'b0;
        bus.mode  = 1'b1;
        bus.dwell = 8'd1;
        for (int c = 0; c < 14; c++) begin
            tick();
            n_cmp++;
            if (bus.d_n !== edn[c]) begin
                n_bad++;
                $display("FAIL bbm_dn c=%0d got=%b exp=%b",
                         c, bus.d_n, edn[c]);
            end
            n_cmp++;
            if (bus.cur_idx !== 2'(eidx[c])) begin
                n_bad++;
                $display("FAIL bbm_idx c=%0d got=%0d exp=%0d",
                         c, bus.cur_idx, eidx[c]);
            end
            n_cmp++;
            if (bus.wrap !== (c == 11)) begin
                n_bad++;
                $display("FAIL bbm_wrap c=%0d got=%b exp=%b",
                         c, bus.wrap, (c == 11));
            end
        end
    endtask
`endif

    task automatic test_async_reset;
        bit found = 1'b0;
        bus.en_n = 1'b1;
        tick();
        bus.en_n  = 1'b0;
        bus.mode  = 1'b1;
        bus.dwell = 8'd2;
        for (int c = 0; c < 40 && !found; c++) begin
            tick();
            if (bus.cur_idx === 2'd2 && bus.d_n === 4'b1101)
                found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL arst_reach got=timeout exp=index2");
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.d_n !== 4'b1111) begin
            n_bad++;
            $display("FAIL arst_dn got=%b exp=1111", bus.d_n);
        end
        n_cmp++;
        if (bus.cur_idx !== 2'd0) begin
            n_bad++;
            $display("FAIL arst_idx got=%0d exp=0", bus.cur_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (bus.d_n !== 4'b0111) begin
            n_bad++;
            $display("FAIL arst_restart got=%b exp=0111", bus.d_n);
        end
        n_cmp++;
        if (bus.wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL arst_wrap got=%b exp=0", bus.wrap);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_direct();
        test_enable();
`ifdef BREAK_BEFORE_MAKE_EN
        test_bbm();
`else
        test_scan();
        test_dwell_change();
`endif
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
